z8_control_unit: RTL and testbench
==================================

Name: z8_control_unit

Overview:
- Parametrised multi-cycle sequencer for the z8 core. Fetches 3-word instructions over a req/ack memory bus and decodes them.
- Contains PC, IR, register file, flags register and a combinational ALU. Retires one instruction at a time.
- Generalises the original 8-bit core in data width, address width and register count, and adds variable-latency memory and conditional jumps.

Parameters:
DATA_W, 8, register/ALU/memory word width (>=8)
ADDR_W, 8, PC and memory address width
NUM_REGS, 4, general registers (power of 2, >=2)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mem_req  out  1  memory transfer request
mem_we  out  1  1=write, 0=read; valid with mem_req
mem_addr  out  ADDR_W  transfer address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data; valid when mem_ack=1
mem_ack  in  1  transfer completes on any edge with mem_req&&mem_ack
pc  out  ADDR_W  current PC
flags  out  4  {overflow,carry,negative,zero}
state  out  3  current FSM state encoding
halted  out  1  core stopped
instr_done  out  1  one-cycle pulse in WRITEBACK
illegal_op  out  1  sticky illegal-opcode trap
dbg_sel  in  $clog2(NUM_REGS)  debug register select
dbg_data  out  DATA_W  combinational read of reg[dbg_sel]

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset state: PC=RESET_PC, all regs=0, flags=0, state=FETCH_OP, halted=0, illegal_op=0, instr_done=0.
  - mem_req is forced 0 in any cycle with rst_n=0.
  - Reset mid-transfer abandons the transfer.
- Instruction format: word0 is the opcode (low 8 bits), word1 is op1, word2 is op2. Each word is fetched from PC, and PC increments by 1 per fetched word, wrapping modulo 2^ADDR_W.
- Operand interpretation:
  - Register index = low $clog2(NUM_REGS) bits of the operand.
  - Address = low ADDR_W bits, zero-extended if DATA_W<ADDR_W.
- Opcodes 0..18, in this order: NOP, LDM, LDR, LDD, STR, STD, ADR, ADD, SBR, SBD, ANR, AND, ORR, ORD, XOR, XOD, CPR, CPD, HALT. New opcodes: JMP=19, JZ=20, JNZ=21, JC=22.
- Opcode semantics (rd=reg[op1], rs=reg[op2], imm=op2):
  - LDM: rd=mem[op2]. LDR: rd=rs. LDD: rd=imm. STR: mem[op1]=rs. STD: mem[op1]=imm.
  - ALU ops: rd = rd op (rs|imm).
  - CPR/CPD: compute rd-src, update flags only, no register write.
  - JMP/JZ/JNZ/JC: PC=op1 if the condition holds (Z=1, Z=0, C=1 respectively; always for JMP), otherwise fall through. op2 ignored.
- Flags: only ALU, CPR and CPD update flags; loads, stores and jumps preserve them.
  - Z = result==0. N = result[DATA_W-1].
  - ADD: C = carry out of bit DATA_W-1; V = signed overflow.
  - SUB/CMP: C = borrow (a<b unsigned); V = signed overflow.
  - AND/OR/XOR: C=0, V=0.
- FSM states: FETCH_OP, FETCH_A, FETCH_B, DECODE, EXECUTE, WRITEBACK, HALTED.
  - Fetch states: mem_req=1, mem_we=0, mem_addr=PC. Advance only on mem_ack.
  - DECODE is always 1 cycle.
  - EXECUTE is 1 cycle, except LDM/STR/STD, which hold mem_req until mem_ack.
  - WRITEBACK is 1 cycle: register/flag/PC update, instr_done=1, then go to FETCH_OP.
  - HALT goes from WRITEBACK to HALTED. HALTED: halted=1, mem_req=0, exits only by reset.
- Handshake:
  - mem_req is decoded from state.
  - addr/we/wdata are stable while mem_req=1 and mem_ack=0.
  - Zero-wait ack is legal: minimum instruction length is 6 cycles (7 with a memory operand).
- Unknown opcode (>22) executes as NOP unless the optional feature is enabled.

Optional Feature:
Z8_ILLEGAL_TRAP_EN
- Defined: an opcode >22 goes DECODE->HALTED. It sets illegal_op=1 (sticky until reset) and halted=1, with no instr_done pulse.
- Undefined: the opcode is treated as NOP (retires normally, instr_done pulses), and illegal_op is tied 0.

Test Plan:
1. Zero-wait memory; program LDD r1,0x05; ADD r1,0xFB (DATA_W=8) -> r1=0x00, flags Z=1 C=1 N=0 V=0; instr_done pulses 6 cycles apart; pc=6.
2. Program LDD r0,0x7F; ADD r0,0x01 -> r0=0x80, V=1 N=1 C=0 Z=0. Then CPD r0,0x80 -> Z=1, r0 stays 0x80. Then JZ 0x20 -> next fetch mem_addr=0x20.
3. STD 0x40,0xAA; LDM r2,0x40 with mem_ack delayed 3 cycles on every transfer -> exactly one write (we=1, addr 0x40, wdata 0xAA); r2=0xAA; addr/wdata stable while waiting; each instruction takes 3 extra cycles per transfer.
4. HALT -> halted=1, state=HALTED, mem_req=0 for 50 cycles with PC frozen. Then rst_n=0 for 1 cycle -> pc=RESET_PC, FETCH_OP resumes.
5. rst_n=0 during EXECUTE of LDM with ack withheld -> mem_req=0 in the reset cycle, destination reg=0 (reset value), PC=RESET_PC.
6. Opcode 0xC8 -> with Z8_ILLEGAL_TRAP_EN: halted=1, illegal_op=1, no instr_done. Without it: NOP retires, pc advances by 3, illegal_op=0.

Source files
------------

// File: rtl/z8_control_unit.sv
// z8_control_unit: multi-cycle fetch/decode/execute sequencer for the z8 core.
// Fetches 3-word instructions (opcode, op1, op2) over a req/ack memory bus,
// then runs DECODE, EXECUTE (with an optional memory transfer) and WRITEBACK.
// Optional feature macro: Z8_ILLEGAL_TRAP_EN. When it is defined, opcodes
// above 22 trap to HALTED and set the sticky illegal_op flag.
module z8_control_unit #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int RESET_PC = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ack,
    output logic [ADDR_W-1:0]           pc,
    output logic [3:0]                  flags,
    output logic [2:0]                  state,
    output logic                        halted,
    output logic                        instr_done,
    output logic                        illegal_op,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
    output logic [DATA_W-1:0]           dbg_data
);
    localparam int REG_W = $clog2(NUM_REGS);

    localparam logic [2:0] S_FETCH_OP  = 3'd0;
    localparam logic [2:0] S_FETCH_A   = 3'd1;
    localparam logic [2:0] S_FETCH_B   = 3'd2;
    localparam logic [2:0] S_DECODE    = 3'd3;
    localparam logic [2:0] S_EXECUTE   = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_HALTED    = 3'd6;

    localparam logic [7:0] OP_LDM  = 8'd1;
    localparam logic [7:0] OP_LDR  = 8'd2;
    localparam logic [7:0] OP_LDD  = 8'd3;
    localparam logic [7:0] OP_STR  = 8'd4;
    localparam logic [7:0] OP_STD  = 8'd5;
    localparam logic [7:0] OP_ADR  = 8'd6;
    localparam logic [7:0] OP_ADD  = 8'd7;
    localparam logic [7:0] OP_SBR  = 8'd8;
    localparam logic [7:0] OP_SBD  = 8'd9;
    localparam logic [7:0] OP_ANR  = 8'd10;
    localparam logic [7:0] OP_AND  = 8'd11;
    localparam logic [7:0] OP_ORR  = 8'd12;
    localparam logic [7:0] OP_ORD  = 8'd13;
    localparam logic [7:0] OP_XOR  = 8'd14;
    localparam logic [7:0] OP_XOD  = 8'd15;
    localparam logic [7:0] OP_CPR  = 8'd16;
    localparam logic [7:0] OP_CPD  = 8'd17;
    localparam logic [7:0] OP_HALT = 8'd18;
    localparam logic [7:0] OP_JMP  = 8'd19;
    localparam logic [7:0] OP_JZ   = 8'd20;
    localparam logic [7:0] OP_JNZ  = 8'd21;
    localparam logic [7:0] OP_JC   = 8'd22;

    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

    // Operand word to address: truncate or zero-extend to ADDR_W bits.
    function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
        return ADDR_W'(v);
    endfunction

    logic [2:0]        state_r, next_state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [7:0]        ir_r;
    logic [DATA_W-1:0] op1_r, op2_r, mdr_r;
    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [3:0]        flags_r;
    logic              exec_mem_r;

    logic [REG_W-1:0]  rd_idx_s, rs_idx_s;
    logic [DATA_W-1:0] rd_val_s, rs_val_s, src_s, alu_res_s;
    logic [DATA_W:0]   sum_s, diff_s;
    logic              alu_c_s, alu_v_s, alu_wr_s, alu_upd_s;
    logic              is_mem_op_s, jump_s;

    assign rd_idx_s    = op1_r[REG_W-1:0];
    assign rs_idx_s    = op2_r[REG_W-1:0];
    assign rd_val_s    = regs_r[rd_idx_s];
    assign rs_val_s    = regs_r[rs_idx_s];
    assign src_s       = ir_r[0] ? op2_r : rs_val_s;
    assign sum_s       = {1'b0, rd_val_s} + {1'b0, src_s};
    assign diff_s      = {1'b0, rd_val_s} - {1'b0, src_s};
    assign is_mem_op_s = (ir_r == OP_LDM) || (ir_r == OP_STR) || (ir_r == OP_STD);

    // ALU: result, carry/borrow and overflow for the current instruction.
    always_comb begin
        alu_res_s = {DATA_W{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        alu_wr_s  = 1'b0;
        alu_upd_s = 1'b1;
        case (ir_r)
            OP_ADR, OP_ADD: begin
                alu_res_s = sum_s[DATA_W-1:0];
                alu_c_s   = sum_s[DATA_W];
                alu_v_s   = (rd_val_s[DATA_W-1] == src_s[DATA_W-1]) &&
                            (sum_s[DATA_W-1] != rd_val_s[DATA_W-1]);
                alu_wr_s  = 1'b1;
            end
            OP_SBR, OP_SBD, OP_CPR, OP_CPD: begin
                alu_res_s = diff_s[DATA_W-1:0];
                alu_c_s   = diff_s[DATA_W];
                alu_v_s   = (rd_val_s[DATA_W-1] != src_s[DATA_W-1]) &&
                            (diff_s[DATA_W-1] != rd_val_s[DATA_W-1]);
                alu_wr_s  = (ir_r == OP_SBR) || (ir_r == OP_SBD);
            end
            OP_ANR, OP_AND: begin
                alu_res_s = rd_val_s & src_s;
                alu_wr_s  = 1'b1;
            end
            OP_ORR, OP_ORD: begin
                alu_res_s = rd_val_s | src_s;
                alu_wr_s  = 1'b1;
            end
            OP_XOR, OP_XOD: begin
                alu_res_s = rd_val_s ^ src_s;
                alu_wr_s  = 1'b1;
            end
            default: alu_upd_s = 1'b0;
        endcase
    end

    // Jump condition evaluated against the flags of earlier instructions.
    always_comb begin
        case (ir_r)
            OP_JMP:  jump_s = 1'b1;
            OP_JZ:   jump_s = flags_r[0];
            OP_JNZ:  jump_s = ~flags_r[0];
            OP_JC:   jump_s = flags_r[2];
            default: jump_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH_OP;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; fetches and memory executes wait for mem_ack.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH_OP: next_state_s = mem_ack ? S_FETCH_A : S_FETCH_OP;
            S_FETCH_A:  next_state_s = mem_ack ? S_FETCH_B : S_FETCH_A;
            S_FETCH_B:  next_state_s = mem_ack ? S_DECODE : S_FETCH_B;
`ifdef Z8_ILLEGAL_TRAP_EN
            S_DECODE:   next_state_s = (ir_r > OP_JC) ? S_HALTED : S_EXECUTE;
`else
            S_DECODE:   next_state_s = S_EXECUTE;
`endif
            S_EXECUTE: begin
                if (is_mem_op_s) begin
                    next_state_s = (exec_mem_r && mem_ack) ? S_WRITEBACK : S_EXECUTE;
                end else begin
                    next_state_s = S_WRITEBACK;
                end
            end
            S_WRITEBACK: next_state_s = (ir_r == OP_HALT) ? S_HALTED : S_FETCH_OP;
            S_HALTED:    next_state_s = S_HALTED;
            default:     next_state_s = S_FETCH_OP;
        endcase
    end

    // Bus outputs decoded from state; the request is suppressed during reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_r;
        mem_wdata = {DATA_W{1'b0}};
        case (state_r)
            S_FETCH_OP, S_FETCH_A, S_FETCH_B: mem_req = rst_n;
            S_EXECUTE: begin
                if (is_mem_op_s) begin
                    mem_req   = rst_n && exec_mem_r;
                    mem_we    = (ir_r != OP_LDM);
                    mem_addr  = (ir_r == OP_LDM) ? to_addr(op2_r) : to_addr(op1_r);
                    mem_wdata = (ir_r == OP_STR) ? rs_val_s : op2_r;
                end else begin
                    mem_req   = 1'b0;
                end
            end
            default: mem_req = 1'b0;
        endcase
    end

    // Datapath: fetch capture, memory data capture and writeback updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r       <= PC_RESET;
            ir_r       <= 8'd0;
            op1_r      <= {DATA_W{1'b0}};
            op2_r      <= {DATA_W{1'b0}};
            mdr_r      <= {DATA_W{1'b0}};
            flags_r    <= 4'd0;
            exec_mem_r <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_r)
                S_FETCH_OP: if (mem_ack) begin ir_r  <= mem_rdata[7:0]; pc_r <= pc_r + PC_ONE; end
                S_FETCH_A:  if (mem_ack) begin op1_r <= mem_rdata;      pc_r <= pc_r + PC_ONE; end
                S_FETCH_B:  if (mem_ack) begin op2_r <= mem_rdata;      pc_r <= pc_r + PC_ONE; end
                S_EXECUTE: begin
                    if (is_mem_op_s) begin
                        exec_mem_r <= 1'b1;
                        if (exec_mem_r && mem_ack) begin
                            mdr_r <= mem_rdata;
                        end
                    end
                end
                S_WRITEBACK: begin
                    exec_mem_r <= 1'b0;
                    if (ir_r == OP_LDM) begin
                        regs_r[rd_idx_s] <= mdr_r;
                    end else if (ir_r == OP_LDR) begin
                        regs_r[rd_idx_s] <= rs_val_s;
                    end else if (ir_r == OP_LDD) begin
                        regs_r[rd_idx_s] <= op2_r;
                    end else if (alu_wr_s) begin
                        regs_r[rd_idx_s] <= alu_res_s;
                    end
                    if (alu_upd_s) begin
                        flags_r <= {alu_v_s, alu_c_s, alu_res_s[DATA_W-1],
                                    (alu_res_s == {DATA_W{1'b0}})};
                    end
                    if (jump_s) begin
                        pc_r <= to_addr(op1_r);
                    end
                end
                default: exec_mem_r <= 1'b0;
            endcase
        end
    end

`ifdef Z8_ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky trap flag, set when an unknown opcode reaches DECODE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (state_r == S_DECODE && ir_r > OP_JC) begin
            illegal_r <= 1'b1;
        end
    end
    assign illegal_op = illegal_r;
`else
    assign illegal_op = 1'b0;
`endif

    assign pc         = pc_r;
    assign flags      = flags_r;
    assign state      = state_r;
    assign halted     = (state_r == S_HALTED);
    assign instr_done = rst_n && (state_r == S_WRITEBACK);
    assign dbg_data   = regs_r[dbg_sel];

endmodule

// File: tb/tb_z8_control_unit.sv
// Testbench for z8_control_unit: behavioural memory with variable ack latency,
// an instruction-level reference model feeding a scoreboard queue, and a
// monitor that checks each retirement reported by instr_done.
module tb_z8_control_unit;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req, mem_we, mem_ack = 1'b0;
    logic [AW-1:0] mem_addr, pc;
    logic [DW-1:0] mem_wdata, mem_rdata = 8'd0, dbg_data;
    logic [3:0]    flags;
    logic [2:0]    state;
    logic          halted, instr_done, illegal_op;
    logic [1:0]    dbg_sel = 2'd0;

    z8_control_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .pc(pc), .flags(flags), .state(state),
        .halted(halted), .instr_done(instr_done), .illegal_op(illegal_op),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct { int pc; int flags; int ridx; int rval; bit halt; } exp_t;
    exp_t sb_q[$];
    exp_t pe;
    bit   pending = 1'b0;

    int checks = 0, errors = 0;
    int prog[256], mem[256], mm[256], mregs[4];
    int mflags, mpc;
    bit m_halt, m_trap;
    int lat_mode = 0, withhold = -1;
    int writes = 0, last_waddr = 0, last_wdata = 0, phase_w0 = 0;
    int cyc = 0, last_done = 0, done_gap = 0;
    bit busy = 1'b0;
    int wcnt = 0, h_bus = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder: latency per transfer, commits writes on the acked cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem = prog;
            busy = 1'b0;
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (!busy) begin
                busy = 1'b1;
                h_bus = {mem_addr, mem_we, mem_wdata};
                wcnt = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
            end else begin
                chk("bus_stable", {mem_addr, mem_we, mem_wdata}, h_bus);
            end
            if (wcnt == 0 && int'(mem_addr) != withhold) begin
                mem_ack = 1'b1;
                mem_rdata = 8'(mem[mem_addr]);
                busy = 1'b0;
                if (mem_we) begin
                    mem[mem_addr] = int'(mem_wdata);
                    writes++;
                    last_waddr = int'(mem_addr);
                    last_wdata = int'(mem_wdata);
                end
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 8'($urandom);
                if (wcnt > 0) wcnt--;
            end
        end else begin
            busy = 1'b0;
            mem_ack = 1'b0;
        end
    end

    // Monitor: pop the expected record on each retirement, check it a cycle later.
    always @(negedge clk) begin
        if (pending) begin
            chk("pc", int'(pc), pe.pc);
            chk("flags", int'(flags), pe.flags);
            chk("reg", int'(dbg_data), pe.rval);
            chk("halted", int'(halted), int'(pe.halt));
            if (!pe.halt) chk("fetch_addr", int'(mem_req) * 256 + int'(mem_addr), 256 + pe.pc);
            pending = 1'b0;
        end
        if (rst_n && instr_done) begin
            done_gap = cyc - last_done;
            last_done = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire: unexpected instr_done at pc 0x%0h, expected none", pc);
            end else begin
                pe = sb_q.pop_front();
                dbg_sel = 2'(pe.ridx);
                pending = 1'b1;
            end
        end
    end

    // Instruction-level reference model over a private copy of memory.
    task automatic run_model(input int nsteps);
        int op, a, b, x, y, r, rd, rs, kind, sr, c, v;
        exp_t e;
        mm = prog;
        for (int i = 0; i < 4; i++) mregs[i] = 0;
        mflags = 0; mpc = 0; m_halt = 1'b0; m_trap = 1'b0;
        for (int n = 0; n < nsteps && !m_halt; n++) begin
            op = mm[mpc]; mpc = (mpc + 1) % 256;
            a  = mm[mpc]; mpc = (mpc + 1) % 256;
            b  = mm[mpc]; mpc = (mpc + 1) % 256;
            rd = a % 4; rs = b % 4;
`ifdef Z8_ILLEGAL_TRAP_EN
            if (op > 22) begin m_trap = 1'b1; m_halt = 1'b1; continue; end
`else
            if (op > 22) op = 0;
`endif
            if (op == 1) mregs[rd] = mm[b];
            else if (op == 2) mregs[rd] = mregs[rs];
            else if (op == 3) mregs[rd] = b;
            else if (op == 4) mm[a] = mregs[rs];
            else if (op == 5) mm[a] = b;
            else if (op >= 6 && op <= 17) begin
                x = mregs[rd];
                y = (op % 2 == 1) ? b : mregs[rs];
                kind = (op - 6) / 2;
                c = 0; v = 0;
                if (kind == 0) begin
                    r = x + y; c = (r > 255); r = r % 256;
                    sr = sgn(x) + sgn(y); v = (sr > 127 || sr < -128);
                end else if (kind == 1 || kind == 5) begin
                    r = (x - y + 256) % 256; c = (x < y);
                    sr = sgn(x) - sgn(y); v = (sr > 127 || sr < -128);
                end else if (kind == 2) r = x & y;
                else if (kind == 3) r = x | y;
                else r = x ^ y;
                mflags = v * 8 + c * 4 + (r >= 128) * 2 + (r == 0);
                if (kind != 5) mregs[rd] = r;
            end
            else if (op == 18) m_halt = 1'b1;
            else if (op == 19) mpc = a;
            else if (op == 20 && (mflags & 1) != 0) mpc = a;
            else if (op == 21 && (mflags & 1) == 0) mpc = a;
            else if (op == 22 && (mflags & 4) != 0) mpc = a;
            e.pc = mpc; e.flags = mflags; e.ridx = rd; e.rval = mregs[rd]; e.halt = m_halt;
            sb_q.push_back(e);
        end
    endtask

    // Load is done by the responder during reset; run until all records retire.
    task automatic run_phase(input int lat, input int nsteps);
        int t, bad;
        rst_n = 1'b0;
        lat_mode = lat;
        repeat (2) @(posedge clk);
        #1;
        phase_w0 = writes;
        run_model(nsteps);
        rst_n = 1'b1;
        t = 0;
        while ((sb_q.size() != 0 || pending) && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        chk("retire_timeout", int'(t < 5000), 1);
        sb_q.delete();
        if (m_halt) begin
            repeat (20) @(posedge clk);
            #1;
            chk("halted_end", int'(halted), 1);
        end
        chk("illegal_op", int'(illegal_op), int'(m_trap));
        if (!m_halt) rst_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != mm[i]) bad++;
        chk("mem_image", bad, 0);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 0;
    endtask

    task automatic gen_random();
        int op;
        for (int i = 0; i < 256; i++) prog[i] = $urandom_range(0, 255);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 15) == 0) op = $urandom_range(23, 255);
            else begin op = $urandom_range(0, 21); if (op >= 18) op++; end
            prog[3*k] = op;
            if (op == 4 || op == 5) prog[3*k+1] = $urandom_range(192, 255);
            else if (op >= 19 && op <= 22) prog[3*k+1] = 3 * $urandom_range(0, 39);
            else prog[3*k+1] = $urandom_range(0, 255);
            prog[3*k+2] = $urandom_range(0, 255);
        end
        for (int i = 120; i < 192; i++) prog[i] = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int t, bad;
        clear_prog();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_done", int'(instr_done), 0);
        chk("rst_req", int'(mem_req), 0);
        chk("rst_flags", int'(flags), 0);
        chk("rst_illegal", int'(illegal_op), 0);

        // LDD r1,5 ; ADD r1,0xFB : wraps to zero with carry, 6 cycles apart
        clear_prog();
        prog[0] = 3; prog[1] = 1; prog[2] = 8'h05;
        prog[3] = 7; prog[4] = 1; prog[5] = 8'hFB;
        run_phase(0, 2);
        chk("t1_gap", done_gap, 6);

        // Signed overflow, compare, then JZ taken to 0x20
        clear_prog();
        prog[0] = 3;  prog[1] = 0;     prog[2] = 8'h7F;
        prog[3] = 7;  prog[4] = 0;     prog[5] = 8'h01;
        prog[6] = 17; prog[7] = 0;     prog[8] = 8'h80;
        prog[9] = 20; prog[10] = 8'h20; prog[11] = 0;
        run_phase(0, 4);

        // STD 0x40,0xAA ; LDM r2,0x40 with three wait cycles per transfer
        clear_prog();
        prog[0] = 5; prog[1] = 8'h40; prog[2] = 8'hAA;
        prog[3] = 1; prog[4] = 2;     prog[5] = 8'h40;
        run_phase(3, 2);
        chk("t3_writes", writes - phase_w0, 1);
        chk("t3_waddr", last_waddr, 8'h40);
        chk("t3_wdata", last_wdata, 8'hAA);
        chk("t3_gap", done_gap, 19);

        // HALT holds for 50 cycles, then a one-cycle reset restarts fetch
        clear_prog();
        prog[0] = 18;
        run_phase(0, 1);
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (mem_req || !halted || state != 3'd6 || pc != 8'd3) bad++;
        end
        chk("t4_halt_hold", bad, 0);
        rst_n = 1'b0;
        #1 chk("t4_rst_req", int'(mem_req), 0);
        @(posedge clk); #1;
        chk("t4_rst_pc", int'(pc), 0);
        chk("t4_rst_state", int'(state), 0);
        rst_n = 1'b1;
        #1 chk("t4_resume_req", int'(mem_req), 1);
        rst_n = 1'b0;

        // Reset while LDM waits for an ack that never comes
        clear_prog();
        prog[0] = 3; prog[1] = 1; prog[2] = 8'h33;
        prog[3] = 1; prog[4] = 1; prog[5] = 8'h80;
        prog[8'h80] = 8'h99;
        lat_mode = 0; withhold = 8'h80;
        repeat (2) @(posedge clk);
        #1;
        run_model(1);
        rst_n = 1'b1;
        t = 0;
        while (!(mem_req && mem_addr == 8'h80) && t < 200) begin @(posedge clk); #1; t++; end
        chk("t5_ldm_req_seen", int'(t < 200), 1);
        chk("t5_ldd_retired", sb_q.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1 chk("t5_rst_req", int'(mem_req), 0);
        @(posedge clk); #1;
        chk("t5_pc", int'(pc), 0);
        chk("t5_reg", int'(dbg_data), 0);
        chk("t5_state", int'(state), 0);
        withhold = -1;
        sb_q.delete();

        // Unknown opcode 0xC8
        clear_prog();
        prog[0] = 8'hC8;
        run_phase(0, 1);

        // Randomized programs under several latency modes
        for (int p = 0; p < 6; p++) begin
            gen_random();
            run_phase((p % 3 == 2) ? -1 : (p % 3), 40);
        end

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
